// File: rtl/irq_pc_scheduler.sv
// irq_pc_scheduler
//   Prioritised, nesting interrupt scheduler for the fetch stage. It arbitrates
//   level-pending sources against the running priority level and redirects the
//   PC mux to a per-source vector. Preempted levels are kept on a small
//   hardware stack that is popped by a retired mret.
//
// Ports:
//   clk          core clock
//   reset        synchronous, active-high reset
//   pend         level pending flag per source
//   enable       per-source enable
//   prio         flattened priorities, source i at [i*PrioWidth +: PrioWidth]
//   vec_base     vector table base address
//   stall        fetch cannot accept a redirect this cycle
//   mret         one-cycle pulse, retired mret
//   sel          PC source select (PC_NORMAL / PC_INTERRUPT)
//   pc_interrupt interrupt target address
//   take         one-cycle pulse, redirect accepted
//   take_id      id of the taken source, valid with take
//   clr_pend     one-hot pending clear, valid with take
//   level        current running priority, 0 = thread level
//   depth        current stack occupancy
//
// Build option:
//   IRQ_TAIL_CHAIN_EN  when defined, an mret in IDLE arbitrates against the
//                      popped level and, on a winner, enters REDIRECT in the
//                      same cycle with the pop and the later push cancelled.

package irq_pc_scheduler_pkg;
  typedef enum logic [0:0] {
    PC_NORMAL    = 1'b0,
    PC_INTERRUPT = 1'b1
  } pc_interrupt_mux_t;
endpackage

module irq_pc_scheduler
  import irq_pc_scheduler_pkg::*;
#(
  parameter int AddrWidth  = 32,
  parameter int NumSrc     = 8,
  parameter int PrioWidth  = 3,
  parameter int StackDepth = 4,
  localparam int IdWidth    = (NumSrc > 1) ? $clog2(NumSrc) : 1,
  localparam int DepthWidth = $clog2(StackDepth + 1),
  localparam int StackIdxW  = (StackDepth > 1) ? $clog2(StackDepth) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NumSrc-1:0]           pend,
  input  logic [NumSrc-1:0]           enable,
  input  logic [NumSrc*PrioWidth-1:0] prio,
  input  logic [AddrWidth-1:0]        vec_base,
  input  logic                        stall,
  input  logic                        mret,
  output pc_interrupt_mux_t           sel,
  output logic [AddrWidth-1:0]        pc_interrupt,
  output logic                        take,
  output logic [IdWidth-1:0]          take_id,
  output logic [NumSrc-1:0]           clr_pend,
  output logic [PrioWidth-1:0]        level,
  output logic [DepthWidth-1:0]       depth
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  state_e                 state_r;
  state_e                 state_s;

  logic [IdWidth-1:0]     id_r;
  logic [PrioWidth-1:0]   prio_r;
  logic [AddrWidth-1:0]   vec_r;
  logic                   chain_r;   // captured redirect replaces the popped frame
  logic [PrioWidth-1:0]   level_r;
  logic [DepthWidth-1:0]  depth_r;
  logic [PrioWidth-1:0]   stack_r [StackDepth];

  logic [StackIdxW-1:0]   top_idx_s;
  logic [StackIdxW-1:0]   push_idx_s;
  logic                   pop_s;
  logic [PrioWidth-1:0]   cmp_level_s;
  logic                   win_found_s;
  logic [IdWidth-1:0]     win_id_s;
  logic [PrioWidth-1:0]   win_prio_s;
  logic                   capture_s;

  // Stack pointers, pop qualifier and the level the arbiter compares against.
  always_comb begin
    top_idx_s  = StackIdxW'(depth_r - DepthWidth'(1));
    push_idx_s = StackIdxW'(depth_r);
    pop_s      = (state_r == ST_IDLE) && mret && (depth_r != {DepthWidth{1'b0}});
`ifdef IRQ_TAIL_CHAIN_EN
    // Chained return: arbitrate as if the pop had already happened.
    cmp_level_s = pop_s ? stack_r[top_idx_s] : level_r;
`else
    cmp_level_s = level_r;
`endif
  end

  // Arbiter: highest priority above cmp_level wins; the strict compare while
  // scanning upward keeps the lowest id on ties.
  always_comb begin
    logic                 hit;
    logic [PrioWidth-1:0] src_prio;
    win_found_s = 1'b0;
    win_id_s    = {IdWidth{1'b0}};
    win_prio_s  = {PrioWidth{1'b0}};
    for (int i = 0; i < NumSrc; i++) begin
      src_prio    = prio[i*PrioWidth +: PrioWidth];
      hit         = pend[i] & enable[i] & (src_prio > cmp_level_s) & (src_prio > win_prio_s);
      win_found_s = win_found_s | hit;
      win_id_s    = hit ? IdWidth'(i) : win_id_s;
      win_prio_s  = hit ? src_prio : win_prio_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
`ifdef IRQ_TAIL_CHAIN_EN
          state_s = win_found_s ? ST_REDIRECT : ST_IDLE;
`else
          state_s = ST_IDLE;
`endif
        end else if (win_found_s && (depth_r < DepthWidth'(StackDepth))) begin
          state_s = ST_REDIRECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        // The captured choice is frozen until fetch accepts it.
        state_s = stall ? ST_REDIRECT : ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    capture_s = (state_r == ST_IDLE) && (state_s == ST_REDIRECT);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM outputs; take is gated by reset so no pulse escapes a reset cycle.
  always_comb begin
    sel          = (state_r == ST_REDIRECT) ? PC_INTERRUPT : PC_NORMAL;
    pc_interrupt = vec_r;
    take         = (state_r == ST_REDIRECT) && !stall && !reset;
    take_id      = id_r;
    clr_pend     = take ? (NumSrc'(1'b1) << id_r) : {NumSrc{1'b0}};
    level        = level_r;
    depth        = depth_r;
  end

  // Captured redirect, running level and stack occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_r    <= {IdWidth{1'b0}};
      prio_r  <= {PrioWidth{1'b0}};
      vec_r   <= {AddrWidth{1'b0}};
      chain_r <= 1'b0;
      level_r <= {PrioWidth{1'b0}};
      depth_r <= {DepthWidth{1'b0}};
    end else begin
      if (capture_s) begin
        id_r    <= win_id_s;
        prio_r  <= win_prio_s;
        vec_r   <= vec_base + (AddrWidth'(win_id_s) << 2'd2);
        chain_r <= pop_s;
      end
      if (take) begin
        level_r <= prio_r;
        // A chained take reuses the frame the mret would have popped.
        if (!chain_r) begin
          depth_r <= depth_r + DepthWidth'(1);
        end
      end else if (pop_s && !capture_s) begin
        level_r <= stack_r[top_idx_s];
        depth_r <= depth_r - DepthWidth'(1);
      end
    end
  end

  // Stack storage: contents are don't-care after reset since depth is cleared.
  always_ff @(posedge clk) begin
    if (take && !chain_r) begin
      stack_r[push_idx_s] <= level_r;
    end
  end

endmodule
